// File: rtl/bcd_alu_pkg.sv
// Shared types and constants for the sequential decimal ADC/SBC unit.
// Optional digit checking is enabled with the BCD_DIGIT_CHECK_EN macro.
package bcd_alu_pkg;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_LO   = 2'd1;
  localparam logic [1:0] S_HI   = 2'd2;
  localparam logic [1:0] S_FLG  = 2'd3;

  localparam logic [3:0] BCD_ADJ = 4'd6;
  localparam logic [3:0] BCD_MAX = 4'd9;

  typedef enum logic [1:0] {
    ST_IDLE = S_IDLE,
    ST_LO   = S_LO,
    ST_HI   = S_HI,
    ST_FLG  = S_FLG
  } state_t;

  // Result plus the flags that cannot be derived from the result alone
  typedef struct packed {
    logic [7:0] result;
    logic       c;
    logic       v;
  } flags_t;

  function automatic logic is_bcd_byte(input logic [7:0] v);
    return (v[7:4] <= BCD_MAX) && (v[3:0] <= BCD_MAX);
  endfunction

endpackage

// File: rtl/bcd_nibble_adj.sv
// One decimal digit of add/subtract with decimal adjust; cin/cout mean
// "carry" for add and "no borrow" for subtract.
module bcd_nibble_adj
  import bcd_alu_pkg::*;
(
  input  logic [3:0] x,
  input  logic [3:0] y,
  input  logic       cin,
  input  logic       sub,
  output logic [3:0] digit,
  output logic       cout,
  output logic       raw_msb
);

  logic [5:0] raw;
  logic [5:0] adj;

  // Six bits hold both the widest sum (31+6) and the most negative difference
  always_comb begin
    raw = sub ? ({2'b00, x} - {2'b00, y} - {5'b00000, ~cin})
              : ({2'b00, x} + {2'b00, y} + {5'b00000, cin});
    adj  = raw;
    cout = 1'b0;
    if (sub) begin
      if (raw[5]) adj = raw - {2'b00, BCD_ADJ};
      cout = ~raw[5];
    end else begin
      if (raw > {2'b00, BCD_MAX}) adj = raw + {2'b00, BCD_ADJ};
      cout = (adj > 6'd15);
    end
    raw_msb = raw[3];
    digit   = adj[3:0];
  end

endmodule

// File: rtl/bcd_alu_seq.sv
// Multi-cycle packed-BCD ADC/SBC, one nibble per cycle through a shared adjuster.
// Define BCD_DIGIT_CHECK_EN to add the bcd_err output.
module bcd_alu_seq
  import bcd_alu_pkg::*;
#(
  parameter int LAT_FLAGS = 0
)
(
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       op_sub,
  input  logic [7:0] a,
  input  logic [7:0] b,
  input  logic       c_in,
  output logic       busy,
  output logic       done,
  output logic [7:0] result,
  output logic       c_out,
  output logic       n_out,
  output logic       v_out,
  output logic       z_out
`ifdef BCD_DIGIT_CHECK_EN
  ,
  output logic       bcd_err
`endif
);

  state_t     state;
  logic [7:0] a_q, b_q;
  logic       sub_q, cy_q;
  logic [3:0] lo_q;
  flags_t     stage_q, hi_flags, fin;
  logic [3:0] nx, ny, digit;
  logic       cout, raw_msb, hi_sel, finish;

  assign hi_sel = (state == ST_HI);
  assign nx     = hi_sel ? a_q[7:4] : a_q[3:0];
  assign ny     = hi_sel ? b_q[7:4] : b_q[3:0];

  bcd_nibble_adj u_adj (
    .x       (nx),
    .y       (ny),
    .cin     (cy_q),
    .sub     (sub_q),
    .digit   (digit),
    .cout    (cout),
    .raw_msb (raw_msb)
  );

  // Overflow uses the pre-adjust bit 7, matching the 65C02 decimal quirk
  always_comb begin
    hi_flags.result = {digit, lo_q};
    hi_flags.c      = cout;
    hi_flags.v      = sub_q ? ((a_q[7] ^ raw_msb) &  (a_q[7] ^ b_q[7]))
                            : ((a_q[7] ^ raw_msb) & ~(a_q[7] ^ b_q[7]));
  end

  assign fin    = (state == ST_FLG) ? stage_q : hi_flags;
  assign finish = (state == ST_FLG) || (hi_sel && (LAT_FLAGS == 0));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= ST_IDLE;
      busy    <= 1'b0;
      done    <= 1'b0;
      result  <= 8'h00;
      c_out   <= 1'b0;
      n_out   <= 1'b0;
      v_out   <= 1'b0;
      z_out   <= 1'b0;
      a_q     <= 8'h00;
      b_q     <= 8'h00;
      sub_q   <= 1'b0;
      cy_q    <= 1'b0;
      lo_q    <= 4'h0;
      stage_q <= '0;
    end else begin
      done <= finish;
      if (finish) begin
        result <= fin.result;
        c_out  <= fin.c;
        v_out  <= fin.v;
        n_out  <= fin.result[7];
        z_out  <= (fin.result == 8'h00);
        busy   <= 1'b0;
        state  <= ST_IDLE;
      end else begin
        case (state)
          ST_IDLE: begin
            if (start) begin
              a_q   <= a;
              b_q   <= b;
              sub_q <= op_sub;
              cy_q  <= c_in;
              busy  <= 1'b1;
              state <= ST_LO;
            end
          end
          ST_LO: begin
            lo_q  <= digit;
            cy_q  <= cout;
            state <= ST_HI;
          end
          ST_HI: begin
            stage_q <= hi_flags;
            state   <= ST_FLG;
          end
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

`ifdef BCD_DIGIT_CHECK_EN
  logic err_q;

  // Digit legality is captured at accept and published alongside done
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      err_q   <= 1'b0;
      bcd_err <= 1'b0;
    end else begin
      if (state == ST_IDLE && start)
        err_q <= !(is_bcd_byte(a) && is_bcd_byte(b));
      if (finish)
        bcd_err <= err_q;
    end
  end
`endif

endmodule

// File: tb/tb_bcd_alu_seq.sv
// Directed self-checking bench for bcd_alu_seq with hand-computed vectors.
// Define BCD_DIGIT_CHECK_EN to also exercise bcd_err.
module tb_bcd_alu_seq;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic       op_sub;
  logic [7:0] a, b;
  logic       c_in;
  logic       busy, done;
  logic [7:0] result;
  logic       c_out, n_out, v_out, z_out;
`ifdef BCD_DIGIT_CHECK_EN
  logic       bcd_err;
`endif

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic       sub;
    logic [7:0] a;
    logic [7:0] b;
    logic       cin;
    logic [7:0] res;
    logic       c;
    logic       n;
    logic       v;
    logic       z;
  } vec_t;

  bcd_alu_seq dut (
    .clk    (clk),
    .reset  (reset),
    .start  (start),
    .op_sub (op_sub),
    .a      (a),
    .b      (b),
    .c_in   (c_in),
    .busy   (busy),
    .done   (done),
    .result (result),
    .c_out  (c_out),
    .n_out  (n_out),
    .v_out  (v_out),
    .z_out  (z_out)
`ifdef BCD_DIGIT_CHECK_EN
    ,
    .bcd_err(bcd_err)
`endif
  );

  always #5 clk = ~clk;

  // Drive one request, let it be accepted, then count falling edges until done
  task automatic applyStimulus(input logic s, input logic [7:0] aa, input logic [7:0] bb,
                               input logic ci, output int lat);
    @(negedge clk);
    op_sub = s; a = aa; b = bb; c_in = ci; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!done && lat < 10);
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b0; op_sub = 1'b0; a = 8'h00; b = 8'h00; c_in = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if ({busy, done, result, c_out, n_out, v_out, z_out} !== 14'h0) begin
      errors++;
      $display("[TB] FAIL reset_state: got busy=%b done=%b result=%h c=%b n=%b v=%b z=%b, want all 0",
               busy, done, result, c_out, n_out, v_out, z_out);
    end
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic run_table(input string tag, input vec_t tbl[$]);
    int lat;
    foreach (tbl[i]) begin
      applyStimulus(tbl[i].sub, tbl[i].a, tbl[i].b, tbl[i].cin, lat);
      checks++;
      if (lat !== 3) begin
        errors++;
        $display("[TB] FAIL %s[%0d] latency: got %0d, want 3", tag, i, lat);
      end
      checks++;
      if ({result, c_out, n_out, v_out, z_out, busy} !==
          {tbl[i].res, tbl[i].c, tbl[i].n, tbl[i].v, tbl[i].z, 1'b0}) begin
        errors++;
        $display("[TB] FAIL %s[%0d] %h,%h: got res=%h c=%b n=%b v=%b z=%b busy=%b, want res=%h c=%b n=%b v=%b z=%b busy=0",
                 tag, i, tbl[i].a, tbl[i].b, result, c_out, n_out, v_out, z_out, busy,
                 tbl[i].res, tbl[i].c, tbl[i].n, tbl[i].v, tbl[i].z);
      end
    end
  endtask

  task automatic test_adc();
    vec_t tbl[$];
    tbl.push_back('{1'b0, 8'h58, 8'h46, 1'b1, 8'h05, 1'b1, 1'b0, 1'b1, 1'b0});
    tbl.push_back('{1'b0, 8'h99, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b1});
    tbl.push_back('{1'b0, 8'h79, 8'h00, 1'b1, 8'h80, 1'b0, 1'b1, 1'b1, 1'b0});
    tbl.push_back('{1'b0, 8'h00, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1});
    tbl.push_back('{1'b0, 8'h1A, 8'h00, 1'b0, 8'h20, 1'b0, 1'b0, 1'b0, 1'b0});
    run_table("adc", tbl);
  endtask

  task automatic test_sbc();
    vec_t tbl[$];
    tbl.push_back('{1'b1, 8'h46, 8'h12, 1'b1, 8'h34, 1'b1, 1'b0, 1'b0, 1'b0});
    tbl.push_back('{1'b1, 8'h12, 8'h21, 1'b1, 8'h91, 1'b0, 1'b1, 1'b0, 1'b0});
    tbl.push_back('{1'b1, 8'h00, 8'h01, 1'b1, 8'h99, 1'b0, 1'b1, 1'b0, 1'b0});
    tbl.push_back('{1'b1, 8'h50, 8'h00, 1'b0, 8'h49, 1'b1, 1'b0, 1'b0, 1'b0});
    tbl.push_back('{1'b1, 8'h80, 8'h10, 1'b1, 8'h70, 1'b1, 1'b0, 1'b1, 1'b0});
    run_table("sbc", tbl);
  endtask

  task automatic test_busy_ignore();
    int lat, pulses;
    @(negedge clk);
    op_sub = 1'b0; a = 8'h12; b = 8'h34; c_in = 1'b0; start = 1'b1;
    @(negedge clk);
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("[TB] FAIL busy_after_accept: got %b, want 1", busy);
    end
    a = 8'h99; b = 8'h99;
    @(negedge clk);
    start = 1'b0;
    lat = 2;
    while (!done && lat < 10) begin
      @(negedge clk);
      lat++;
    end
    checks++;
    if (lat !== 3 || result !== 8'h46 || c_out !== 1'b0) begin
      errors++;
      $display("[TB] FAIL busy_ignore: got lat=%0d res=%h c=%b, want lat=3 res=46 c=0", lat, result, c_out);
    end
    pulses = 0;
    repeat (6) begin
      @(negedge clk);
      if (done) pulses++;
    end
    checks++;
    if (pulses !== 0) begin
      errors++;
      $display("[TB] FAIL busy_no_queue: got %0d extra done pulses, want 0", pulses);
    end
  endtask

  task automatic test_back_to_back();
    int lat;
    @(negedge clk);
    op_sub = 1'b0; a = 8'h25; b = 8'h25; c_in = 1'b0; start = 1'b1;
    @(posedge clk);
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!done && lat < 10);
    checks++;
    if (lat !== 3 || result !== 8'h50 || busy !== 1'b0) begin
      errors++;
      $display("[TB] FAIL b2b_first: got lat=%0d res=%h busy=%b, want lat=3 res=50 busy=0", lat, result, busy);
    end
    op_sub = 1'b1; a = 8'h50; b = 8'h25; c_in = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
      if (lat == 1) begin
        checks++;
        if (busy !== 1'b1 || done !== 1'b0) begin
          errors++;
          $display("[TB] FAIL b2b_accept: got busy=%b done=%b, want busy=1 done=0", busy, done);
        end
      end
    end while (!done && lat < 10);
    checks++;
    if (lat !== 3 || result !== 8'h25 || c_out !== 1'b1) begin
      errors++;
      $display("[TB] FAIL b2b_second: got lat=%0d res=%h c=%b, want lat=3 res=25 c=1", lat, result, c_out);
    end
    @(negedge clk);
    checks++;
    if (done !== 1'b0 || result !== 8'h25) begin
      errors++;
      $display("[TB] FAIL done_pulse_hold: got done=%b res=%h, want done=0 res=25", done, result);
    end
  endtask

  task automatic test_reset_mid_op();
    int pulses;
    @(negedge clk);
    op_sub = 1'b0; a = 8'h33; b = 8'h44; c_in = 1'b0; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    @(posedge clk);
    #2 reset = 1'b1;
    #1;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || result !== 8'h00 || c_out !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset_in_hi: got busy=%b done=%b res=%h c=%b, want 0 0 00 0", busy, done, result, c_out);
    end
    @(negedge clk);
    reset = 1'b0;
    pulses = 0;
    repeat (6) begin
      @(negedge clk);
      if (done) pulses++;
    end
    checks++;
    if (pulses !== 0 || busy !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset_discard: got %0d done pulses busy=%b, want 0 and busy=0", pulses, busy);
    end
  endtask

`ifdef BCD_DIGIT_CHECK_EN
  task automatic test_digit_check();
    int lat;
    applyStimulus(1'b0, 8'h1A, 8'h00, 1'b0, lat);
    checks++;
    if (bcd_err !== 1'b1 || result !== 8'h20) begin
      errors++;
      $display("[TB] FAIL bcd_err_set: got err=%b res=%h, want err=1 res=20", bcd_err, result);
    end
    applyStimulus(1'b0, 8'h12, 8'h34, 1'b0, lat);
    checks++;
    if (bcd_err !== 1'b0 || result !== 8'h46) begin
      errors++;
      $display("[TB] FAIL bcd_err_clear: got err=%b res=%h, want err=0 res=46", bcd_err, result);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_adc();
    test_sbc();
    test_busy_ignore();
    test_back_to_back();
    test_reset_mid_op();
`ifdef BCD_DIGIT_CHECK_EN
    test_digit_check();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
